// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared encodings for the memory access controller: transfer
//            size codes, controller state type and byte-lane count.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Number of byte lanes in one memory word
  localparam int BYTE_LANES = 4;

  // Transfer size encodings carried on req_size
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Combinational byte-lane logic. Store side produces byte write
//            enables and lane-replicated write data; load side extracts the
//            addressed byte/half from a memory word and sign/zero-extends it.
//            Half and word accesses ignore the address bits below their own
//            alignment, so misaligned low bits are naturally masked here.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            wr_size,
  input  logic [1:0]            wr_lo,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [BYTE_LANES-1:0] wr_be,
  output logic [DATA_WIDTH-1:0] wr_din,
  input  logic [1:0]            rd_size,
  input  logic [1:0]            rd_lo,
  input  logic                  rd_unsigned,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [7:0]  w_rd_byte;
  logic [15:0] w_rd_half;
  logic        w_sign;

  // Store side: enables follow the addressed lanes, data replicated on all lanes
  always_comb begin
    wr_be  = '0;
    wr_din = '0;
    case (wr_size)
      SIZE_BYTE: begin
        wr_be  = 4'b0001 << wr_lo;
        wr_din = {BYTE_LANES{wr_data[7:0]}};
      end
      SIZE_HALF: begin
        wr_be  = wr_lo[1] ? 4'b1100 : 4'b0011;
        wr_din = {2{wr_data[15:0]}};
      end
      SIZE_WORD: begin
        wr_be  = 4'b1111;
        wr_din = wr_data;
      end
      default: begin
        wr_be  = '0;
        wr_din = '0;
      end
    endcase
  end

  // Load side: select the addressed lane, then extend to a full word
  always_comb begin
    w_rd_byte = 8'h00;
    w_rd_half = 16'h0000;
    w_sign    = 1'b0;
    rd_data   = '0;
    case (rd_lo)
      2'd0:    w_rd_byte = rd_word[7:0];
      2'd1:    w_rd_byte = rd_word[15:8];
      2'd2:    w_rd_byte = rd_word[23:16];
      default: w_rd_byte = rd_word[31:24];
    endcase
    w_rd_half = rd_lo[1] ? rd_word[31:16] : rd_word[15:0];
    case (rd_size)
      SIZE_BYTE: begin
        w_sign  = ~rd_unsigned & w_rd_byte[7];
        rd_data = {{(DATA_WIDTH-8){w_sign}}, w_rd_byte};
      end
      SIZE_HALF: begin
        w_sign  = ~rd_unsigned & w_rd_half[15];
        rd_data = {{(DATA_WIDTH-16){w_sign}}, w_rd_half};
      end
      SIZE_WORD: rd_data = rd_word;
      default:   rd_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Load/store initiator for a synchronous single-port word memory.
//            Accepts byte/half/word requests, performs one memory access
//            (memory samples on the falling edge inside ACCESS), and returns
//            the extended load data on a valid/ready response channel.
//            Optional build macro: MEM_MISALIGN_TRAP_EN - reject misaligned
//            half/word accesses with rsp_err instead of masking low bits.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic [BYTE_LANES-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  state_t r_state, w_state_nxt;

  // Registered outputs
  logic                  r_req_ready, w_req_ready_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err,   w_rsp_err_nxt;
  logic                  r_mem_en,    w_mem_en_nxt;
  logic [BYTE_LANES-1:0] r_mem_we,    w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem_din,   w_mem_din_nxt;

  // Request attributes kept for the read-data extraction in ACCESS
  logic                  r_write,     w_write_nxt;
  logic [1:0]            r_size,      w_size_nxt;
  logic                  r_unsigned,  w_unsigned_nxt;
  logic [1:0]            r_lo,        w_lo_nxt;

  logic [BYTE_LANES-1:0] w_wr_be;
  logic [DATA_WIDTH-1:0] w_wr_din;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_illegal;

  mem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane (
    .wr_size     (req_size),
    .wr_lo       (req_addr[1:0]),
    .wr_data     (req_wdata),
    .wr_be       (w_wr_be),
    .wr_din      (w_wr_din),
    .rd_size     (r_size),
    .rd_lo       (r_lo),
    .rd_unsigned (r_unsigned),
    .rd_word     (mem_dout),
    .rd_data     (w_rd_data)
  );

  // Request legality: reserved size always traps; misalignment only when enabled
`ifdef MEM_MISALIGN_TRAP_EN
  assign w_illegal = (req_size == SIZE_RSVD)
                   || ((req_size == SIZE_HALF) && req_addr[0])
                   || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign w_illegal = (req_size == SIZE_RSVD);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and next values of all registered outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready_nxt = r_req_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = '0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_din_nxt   = r_mem_din;
    w_write_nxt     = r_write;
    w_size_nxt      = r_size;
    w_unsigned_nxt  = r_unsigned;
    w_lo_nxt        = r_lo;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_req_ready_nxt = 1'b0;
          if (w_illegal) begin
            // Rejected without touching the memory
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = '0;
            w_state_nxt     = RESP;
          end else begin
            w_mem_en_nxt   = 1'b1;
            w_mem_we_nxt   = req_write ? w_wr_be : '0;
            w_mem_addr_nxt = req_addr[ADDR_WIDTH+1:2];
            w_mem_din_nxt  = w_wr_din;
            w_write_nxt    = req_write;
            w_size_nxt     = req_size;
            w_unsigned_nxt = req_unsigned;
            w_lo_nxt       = req_addr[1:0];
            w_state_nxt    = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Memory has sampled at the falling edge; read data is valid now
        w_rsp_valid_nxt = 1'b1;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = r_write ? '0 : w_rd_data;
        w_state_nxt     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_req_ready_nxt = 1'b1;
        w_rsp_valid_nxt = 1'b0;
        w_state_nxt     = IDLE;
      end
    endcase
  end

  // Output and request-attribute registers; reset kills any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_write     <= 1'b0;
      r_size      <= SIZE_BYTE;
      r_unsigned  <= 1'b0;
      r_lo        <= 2'b00;
    end else begin
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_din   <= w_mem_din_nxt;
      r_write     <= w_write_nxt;
      r_size      <= w_size_nxt;
      r_unsigned  <= w_unsigned_nxt;
      r_lo        <= w_lo_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed self-checking bench for mem_access_ctrl with a
//            falling-edge word memory model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic                  req_write = 1'b0;
  logic [1:0]            req_size = 2'b00;
  logic                  req_unsigned = 1'b0;
  logic [ADDR_WIDTH+1:0] req_addr = '0;
  logic [DATA_WIDTH-1:0] req_wdata = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  mem_en;
  logic [3:0]            mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  mem_access_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous memory sampled on the falling edge, read-before-write
  always @(negedge clk) begin
    if (mem_en) begin
      mem_dout <= mem[mem_addr];
      for (int l = 0; l < 4; l++)
        if (mem_we[l]) mem[mem_addr][8*l +: 8] <= mem_din[8*l +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request through the full handshake; hold = cycles of response backpressure
  task automatic issue(input string tag, input logic w, input logic [1:0] sz, input logic u,
                       input logic [11:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic [3:0] exp_we, input logic [31:0] exp_din, input int hold);
    exp_t e;
    logic [31:0] prev;
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ":ready_in"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    e.rdata = exp_rd; e.err = exp_err;
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
    chk({tag, ":ready_busy"}, {31'b0, req_ready}, 32'd0);
    if (exp_err) begin
      chk({tag, ":no_mem_en"}, {31'b0, mem_en}, 32'd0);
      chk({tag, ":rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    end else begin
      chk({tag, ":mem_en"}, {31'b0, mem_en}, 32'd1);
      chk({tag, ":mem_we"}, {28'b0, mem_we}, {28'b0, exp_we});
      chk({tag, ":mem_addr"}, {22'b0, mem_addr}, {22'b0, a[11:2]});
      if (w) chk({tag, ":mem_din"}, mem_din, exp_din);
      chk({tag, ":rsp_early"}, {31'b0, rsp_valid}, 32'd0);
      tick();
      chk({tag, ":mem_en_off"}, {31'b0, mem_en}, 32'd0);
      chk({tag, ":rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    end
    // Backpressure with a competing request that must not be accepted
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_size = SIZE_WORD; req_addr = 12'h000;
      prev = rsp_rdata;
      tick();
      chk({tag, ":hold_valid"}, {31'b0, rsp_valid}, 32'd1);
      chk({tag, ":hold_rdata"}, rsp_rdata, prev);
      chk({tag, ":hold_ready"}, {31'b0, req_ready}, 32'd0);
      chk({tag, ":hold_no_en"}, {31'b0, mem_en}, 32'd0);
    end
    req_valid = 1'b0;
    if (rsp_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ":rdata"}, rsp_rdata, e.rdata);
      chk({tag, ":err"}, {31'b0, rsp_err}, {31'b0, e.err});
    end else begin
      chk({tag, ":rsp_missing"}, {31'b0, rsp_valid}, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, ":rsp_done"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, ":ready_back"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = 32'hC0DE0000 | 32'(i);

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst:req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst:rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst:rsp_rdata", rsp_rdata, 32'd0);
    chk("rst:rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst:mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst:mem_we", {28'b0, mem_we}, 32'd0);
    chk("rst:mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("rst:mem_din", mem_din, 32'd0);
    rst_n = 1'b1;
    tick();

    // Word store/load
    issue("st_w", 1'b1, SIZE_WORD, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF, 0);
    issue("ld_w", 1'b0, SIZE_WORD, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000, 32'h0, 0);
    // Byte store into lane 3, signed and unsigned readback
    issue("st_b", 1'b1, SIZE_BYTE, 1'b0, 12'h013, 32'h000000A5, 32'h0, 1'b0, 4'b1000, 32'hA5A5A5A5, 0);
    issue("ld_bs", 1'b0, SIZE_BYTE, 1'b0, 12'h013, 32'h0, 32'hFFFFFFA5, 1'b0, 4'b0000, 32'h0, 0);
    issue("ld_bu", 1'b0, SIZE_BYTE, 1'b1, 12'h013, 32'h0, 32'h000000A5, 1'b0, 4'b0000, 32'h0, 0);
    issue("ld_b1", 1'b0, SIZE_BYTE, 1'b0, 12'h011, 32'h0, 32'hFFFFFFBE, 1'b0, 4'b0000, 32'h0, 0);
    // Half store to upper half, signed load; untouched lower half unsigned
    issue("st_h", 1'b1, SIZE_HALF, 1'b0, 12'h022, 32'h00008001, 32'h0, 1'b0, 4'b1100, 32'h80018001, 0);
    issue("ld_hs", 1'b0, SIZE_HALF, 1'b0, 12'h022, 32'h0, 32'hFFFF8001, 1'b0, 4'b0000, 32'h0, 0);
    issue("ld_hu", 1'b0, SIZE_HALF, 1'b1, 12'h020, 32'h0, 32'h00000008, 1'b0, 4'b0000, 32'h0, 0);
    // Reserved size is always rejected
    issue("rsvd", 1'b1, SIZE_RSVD, 1'b0, 12'h040, 32'h12345678, 32'h0, 1'b1, 4'b0000, 32'h0, 0);
    // Misaligned word load: trapped or masked depending on build
`ifdef MEM_MISALIGN_TRAP_EN
    issue("mis_w", 1'b0, SIZE_WORD, 1'b0, 12'h005, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 0);
`else
    issue("mis_w", 1'b0, SIZE_WORD, 1'b0, 12'h005, 32'h0, 32'hC0DE0001, 1'b0, 4'b0000, 32'h0, 0);
`endif
    // Response backpressure for 5 cycles
    issue("bp", 1'b0, SIZE_WORD, 1'b0, 12'h010, 32'h0, 32'hA5ADBEEF, 1'b0, 4'b0000, 32'h0, 5);

    // Reset during ACCESS of a store: no write, no response
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_WORD; req_unsigned = 1'b0;
    req_addr = 12'h030; req_wdata = 32'h11111111;
    tick();
    req_valid = 1'b0;
    chk("abort:mem_en_on", {31'b0, mem_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort:mem_en_off", {31'b0, mem_en}, 32'd0);
    chk("abort:mem_we_off", {28'b0, mem_we}, 32'd0);
    repeat (2) tick();
    chk("abort:no_rsp", {31'b0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("abort:ready", {31'b0, req_ready}, 32'd1);
    chk("abort:no_rsp2", {31'b0, rsp_valid}, 32'd0);
    issue("abort_rb", 1'b0, SIZE_WORD, 1'b0, 12'h030, 32'h0, 32'hC0DE000C, 1'b0, 4'b0000, 32'h0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
